vram_snapshot_streamer: RTL

VRAM_SNAPSHOT_STREAMER -- requirements
Module: vram_snapshot_streamer

---
 rtl/vram_snapshot_streamer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vram_snapshot_streamer.sv
// Streams one VRAM snapshot per vsync rising edge as GRID_W*GRID_H palette-coloured cell beats.
// Latency: first beat valid 3 cycles after the vsync edge is sampled, then one beat per 3 cycles.
// Backpressure: SEND holds px_* stable until px_ready; vsync edges while busy only bump overrun_count.
module vram_snapshot_streamer #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        vsync_pulse,
    input  logic        capture_en,
    output logic [10:0] vram_rd_addr,
    input  logic [1:0]  vram_rd_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [11:0] px_rgb,
    output logic [5:0]  px_x,
    output logic [4:0]  px_y,
    output logic        px_sof,
    output logic        px_eol,
    output logic        px_eof,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);

    localparam logic [5:0] X_LAST = 6'(GRID_W - 1);
    localparam logic [4:0] Y_LAST = 5'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        prev_vsync;
    logic        vsync_edge;
    logic        start;
    logic        accept;
    logic        last_cell;
    logic [5:0]  cell_x;
    logic [4:0]  cell_y;

    function automatic logic [11:0] palette(input logic [1:0] code);
        case (code)
            2'b00:   palette = 12'h009;
            2'b01:   palette = 12'h0C0;
            2'b10:   palette = 12'h3F3;
            default: palette = 12'hF00;
        endcase
    endfunction

    assign vsync_edge = vsync_pulse & ~prev_vsync;
    assign start      = (state == IDLE) && vsync_edge && capture_en;
    assign accept     = (state == SEND) && px_ready;
    assign last_cell  = (cell_x == X_LAST) && (cell_y == Y_LAST);
    assign px_valid   = (state == SEND);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (px_ready) state_nxt = last_cell ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // vram_rd_addr doubles as the linear cell counter; it is loaded on entry to
    // FETCH so the registered VRAM sees it in FETCH and returns data during LOAD.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            prev_vsync    <= 1'b0;
            overrun_count <= 8'd0;
            frame_count   <= 16'd0;
            busy          <= 1'b0;
            cell_x        <= 6'd0;
            cell_y        <= 5'd0;
            vram_rd_addr  <= 11'd0;
            px_rgb        <= 12'd0;
            px_x          <= 6'd0;
            px_y          <= 5'd0;
            px_sof        <= 1'b0;
            px_eol        <= 1'b0;
            px_eof        <= 1'b0;
        end else begin
            prev_vsync <= vsync_pulse;

            if (vsync_edge && (state != IDLE) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end

            if (start) begin
                cell_x       <= 6'd0;
                cell_y       <= 5'd0;
                vram_rd_addr <= 11'd0;
                frame_count  <= frame_count + 16'd1;
                busy         <= 1'b1;
            end

            if (state == LOAD) begin
                px_rgb <= palette(vram_rd_data);
                px_x   <= cell_x;
                px_y   <= cell_y;
                px_sof <= (cell_x == 6'd0) && (cell_y == 5'd0);
                px_eol <= (cell_x == X_LAST);
                px_eof <= last_cell;
            end

            if (accept) begin
                if (last_cell) begin
                    busy <= 1'b0;
                end else begin
                    if (cell_x == X_LAST) begin
                        cell_x <= 6'd0;
                        cell_y <= cell_y + 5'd1;
                    end else begin
                        cell_x <= cell_x + 6'd1;
                    end
                    vram_rd_addr <= vram_rd_addr + 11'd1;
                end
            end
        end
    end

endmodule
